button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
// - N-channel button front end: per-channel 2-FF synchroniser, debounce, press/release edge pulses, optional hold-to-repeat.
// - Supersedes separate debounce+pulser pairs; sits between board buttons (btnc/u/d/l/r) and user_io on the 65 MHz clock.
// - Repeat lets a held direction button step the cursor continuously.
// PARAMETERS
// - N_CH          5           number of independent button channels
// - DB_COUNT      1_000_000   cycles input must be stable before clean_out changes (>=2)
// - REPEAT_DELAY  32_500_000  cycles from press to first repeat_pulse (0.5 s @ 65 MHz, >=2)
// - REPEAT_PERIOD 6_500_000   cycles between subsequent repeat_pulses (0.1 s @ 65 MHz, >=2)
// - CNT_W         $clog2(max(DB_COUNT,REPEAT_DELAY,REPEAT_PERIOD)+1)  derived counter width; do not override
// PORTS
// - clk_in         in   1     system clock (65 MHz)
// - rst_in_n       in   1     asynchronous, active-low reset
// - noisy_in       in   N_CH  raw button levels, asynchronous to clk_in
// - repeat_en      in   N_CH  per-channel enable for hold-to-repeat (synchronous)
// - clean_out      out  N_CH  debounced level
// - press_pulse    out  N_CH  1-cycle pulse on debounced 0->1
// - release_pulse  out  N_CH  1-cycle pulse on debounced 1->0
// - repeat_pulse   out  N_CH  1-cycle pulse per auto-repeat tick
// - event_pulse    out  N_CH  press_pulse | repeat_pulse (drop-in for old pulser output)
// BEHAVIOUR
// - Reset (async assert, sync release): all sync flops, clean_out, all pulses, all counters = 0; FSM = IDLE.
// - All outputs registered; channels fully independent; no cross-channel priority.
// - Sync: noisy -> s1 -> s2; debounce logic sees s2 only (2-cycle latency).
// - Debounce: if s2 != cand: cand<=s2, db_cnt<=0; else if db_cnt==DB_COUNT-1 and cand!=clean_out: clean_out<=cand;
//   else db_cnt increments, saturating at DB_COUNT-1. Glitch shorter than DB_COUNT cycles never reaches clean_out.
// - Latency: noisy step at edge 0, held stable -> clean_out changes at edge DB_COUNT+2.
// - press_pulse/release_pulse high exactly in the first cycle clean_out shows the new level.
// - Repeat FSM per channel (rpt_cnt counts cycles):
//   IDLE: on press -> DELAY, rpt_cnt<=0.
//   DELAY: rpt_cnt==REPEAT_DELAY-1 and repeat_en -> pulse, rpt_cnt<=0, -> REPEAT.
//   REPEAT: rpt_cnt==REPEAT_PERIOD-1 and repeat_en -> pulse, rpt_cnt<=0; stay.
//   Any state: release -> IDLE, rpt_cnt<=0, no repeat_pulse that cycle (release wins).
// - repeat_en low while held: no repeat_pulse; rpt_cnt holds at terminal value; pulse fires the cycle after
//   repeat_en returns high (then periodic from there). repeat_en never affects press/release pulses.
// - press_pulse and repeat_pulse are never high in the same cycle (first repeat >= REPEAT_DELAY after press).
// - Reset mid-hold: outputs drop to 0; after release, a still-held button is re-debounced and yields a fresh press_pulse.
// - Counters never wrap: all compare-and-clear or saturate.
// STRUCTURE
// - Shared package btn_pkg: typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;
//   default timing localparams for 65 MHz (DB_COUNT_65M, REPEAT_DELAY_65M, REPEAT_PERIOD_65M).
// - Sub-module button_channel (one sync+debounce+repeat FSM, same parameters, scalar ports);
//   top is a generate loop of N_CH instances plus event_pulse OR.
// TESTING (sim params: N_CH=2, DB_COUNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
// - Reset: hold rst_in_n=0 with noisy_in=2'b11 for 5 cycles -> every output 0; release -> ch0/1 clean_out rise at cycle 6 after release.
// - Bounce: ch0 toggles every 2 cycles for 20 cycles then settles 1 -> exactly one press_pulse, clean_out rises 6 cycles after last toggle.
// - Repeat: ch0 press held 40 cycles, repeat_en=1 -> repeat_pulse at press+10, +13, +16 ... (10 pulses); event_pulse = 11 pulses.
// - Gating: as above but repeat_en=0 from press+5 to press+20 -> no repeat pulses in window; pulse at press+21, then +24 ...
// - Release race: release timed so clean_out falls at press+13 -> release_pulse only, no repeat_pulse, FSM back to IDLE.
// - Independence: ch0 held repeating while ch1 pressed/released -> ch1 press/release pulses correct, ch0 repeat timing unchanged.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and 65 MHz timing defaults for the button conditioner.
// Also provides the helper that sizes the shared cycle counters.
package btn_pkg;

    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

    localparam int unsigned DB_COUNT_65M      = 1_000_000;
    localparam int unsigned REPEAT_DELAY_65M  = 32_500_000;
    localparam int unsigned REPEAT_PERIOD_65M = 6_500_000;

    // Width holding 0..max(a,b,c); the counters only ever reach value-1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, debounce, press/release pulses,
// and the hold-to-repeat state machine. All outputs are registered.
module button_channel
    import btn_pkg::*;
#(
    parameter int unsigned DB_COUNT      = DB_COUNT_65M,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_65M,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_65M
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic noisy_in,
    input  logic repeat_en,
    output logic clean_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W = cnt_width(DB_COUNT, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             s1_q, s1_d, s2_q, s2_d;
    logic             cand_q, cand_d;
    logic             clean_q, clean_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             press_q, press_d, release_q, release_d, repeat_q, repeat_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    rpt_state_t       state_q, state_d;
    logic             rise, fall;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            cand_q    <= 1'b0;
            clean_q   <= 1'b0;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            rpt_cnt_q <= '0;
            state_q   <= RPT_IDLE;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            cand_q    <= cand_d;
            clean_q   <= clean_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            rpt_cnt_q <= rpt_cnt_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        s1_d      = noisy_in;
        s2_d      = s1_q;
        cand_d    = cand_q;
        clean_d   = clean_q;
        db_cnt_d  = db_cnt_q;
        repeat_d  = 1'b0;
        rpt_cnt_d = rpt_cnt_q;
        state_d   = state_q;

        if (s2_q != cand_q) begin
            cand_d   = s2_q;
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            if (cand_q != clean_q) clean_d = cand_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end

        // Edges are taken from the next-state level so the pulses line up
        // with the first cycle clean_out shows the new level.
        rise      = clean_d & ~clean_q;
        fall      = ~clean_d & clean_q;
        press_d   = rise;
        release_d = fall;

        if (fall) begin
            state_d   = RPT_IDLE;
            rpt_cnt_d = '0;
        end else begin
            unique case (state_q)
                RPT_IDLE: begin
                    if (rise) begin
                        state_d   = RPT_DELAY;
                        rpt_cnt_d = '0;
                    end
                end
                RPT_DELAY: begin
                    if (rpt_cnt_q == RD_LAST) begin
                        if (repeat_en) begin
                            repeat_d  = 1'b1;
                            rpt_cnt_d = '0;
                            state_d   = RPT_REPEAT;
                        end
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rpt_cnt_q == RP_LAST) begin
                        if (repeat_en) begin
                            repeat_d  = 1'b1;
                            rpt_cnt_d = '0;
                        end
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
                default: state_d = RPT_IDLE;
            endcase
        end
    end

    assign clean_out     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel button front end: one independent button_channel per input,
// plus the combined press-or-repeat event output.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_CH          = 5,
    parameter int unsigned DB_COUNT      = DB_COUNT_65M,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_65M,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_65M
) (
    input  logic            clk_in,
    input  logic            rst_in_n,
    input  logic [N_CH-1:0] noisy_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic [N_CH-1:0] event_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .DB_COUNT     (DB_COUNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk_in       (clk_in),
            .rst_in_n     (rst_in_n),
            .noisy_in     (noisy_in[i]),
            .repeat_en    (repeat_en[i]),
            .clean_out    (clean_out[i]),
            .press_pulse  (press_pulse[i]),
            .release_pulse(release_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

    // Both terms are registered and never high together.
    assign event_pulse = press_pulse | repeat_pulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a per-edge reference model pushes
// expected outputs; a monitor pops and compares one cycle bundle at a time.
module tb_button_conditioner;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int HL = DB + 3;

    logic         clk_in = 1'b0;
    logic         rst_in_n;
    logic [N-1:0] noisy_in, repeat_en;
    logic [N-1:0] clean_out, press_pulse, release_pulse, repeat_pulse, event_pulse;

    always #5 clk_in = ~clk_in;

    button_conditioner #(
        .N_CH         (N),
        .DB_COUNT     (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk_in       (clk_in),
        .rst_in_n     (rst_in_n),
        .noisy_in     (noisy_in),
        .repeat_en    (repeat_en),
        .clean_out    (clean_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .event_pulse  (event_pulse)
    );

    int checks = 0;
    int errors = 0;

    logic [5*N-1:0] exp_q[$];

    // Reference model: input sample history, debounced level, hold state and
    // the absolute edge at which the next repeat becomes due.
    logic [HL-1:0] hist [N];
    logic [N-1:0]  m_clean, m_held;
    int            due [N];
    int            t;
    int            m_press [N], m_rel [N], m_rpt [N];
    int            n_press [N], n_rel [N], n_rpt [N];

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic clear_counts();
        for (int c = 0; c < N; c++) begin
            m_press[c] = 0; m_rel[c] = 0; m_rpt[c] = 0;
            n_press[c] = 0; n_rel[c] = 0; n_rpt[c] = 0;
        end
    endtask

    // Drive the inputs seen by the next rising edge and predict its outputs.
    task automatic drive(input logic r, input logic [N-1:0] n, input logic [N-1:0] e);
        logic [N-1:0] p, rl, rp;
        @(negedge clk_in);
        rst_in_n  = r;
        noisy_in  = n;
        repeat_en = e;
        t++;
        p = '0; rl = '0; rp = '0;
        for (int c = 0; c < N; c++) begin
            if (!r) begin
                hist[c]   = '0;
                m_clean[c] = 1'b0;
                m_held[c]  = 1'b0;
            end else begin
                hist[c] = {hist[c][HL-2:0], n[c]};
                // Level accepted once DB+1 consecutive samples, seen two edges late, agree.
                if (hist[c][DB+2:2] == '1 && !m_clean[c]) begin
                    m_clean[c] = 1'b1; p[c] = 1'b1;
                end else if (hist[c][DB+2:2] == '0 && m_clean[c]) begin
                    m_clean[c] = 1'b0; rl[c] = 1'b1;
                end
                if (rl[c]) begin
                    m_held[c] = 1'b0;
                end else if (p[c]) begin
                    m_held[c] = 1'b1;
                    due[c]    = t + RD;
                end else if (m_held[c] && t >= due[c] && e[c]) begin
                    rp[c]  = 1'b1;
                    due[c] = t + RP;
                end
            end
            m_press[c] += int'(p[c]);
            m_rel[c]   += int'(rl[c]);
            m_rpt[c]   += int'(rp[c]);
        end
        exp_q.push_back({m_clean, p, rl, rp, p | rp});
    endtask

    task automatic settle();
        @(posedge clk_in);
        #2;
    endtask

    initial begin : monitor
        logic [5*N-1:0] got, want;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {clean_out, press_pulse, release_pulse, repeat_pulse, event_pulse};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs t=%0d got clean/press/rel/rpt/evt=%b expected %b",
                             $time, got, want);
                end
                for (int c = 0; c < N; c++) begin
                    n_press[c] += int'(press_pulse[c]);
                    n_rel[c]   += int'(release_pulse[c]);
                    n_rpt[c]   += int'(repeat_pulse[c]);
                end
            end
        end
    end

    initial begin : stimulus
        logic [N-1:0] lvl, en;
        rst_in_n  = 1'b0;
        noisy_in  = '0;
        repeat_en = '0;
        t         = 0;
        m_clean   = '0;
        m_held    = '0;
        for (int c = 0; c < N; c++) begin
            hist[c] = '0;
            due[c]  = 0;
        end
        clear_counts();

        // Reset held with buttons pressed, then released.
        repeat (5) drive(1'b0, 2'b11, 2'b00);
        clear_counts();
        repeat (12) drive(1'b1, 2'b11, 2'b00);
        settle();
        chk("reset_rise_ch0", n_press[0], 1);
        chk("reset_rise_ch1", n_press[1], 1);
        repeat (10) drive(1'b1, 2'b00, 2'b00);

        // Bounce: toggle every 2 cycles, then settle high.
        clear_counts();
        for (int i = 0; i < 20; i++) drive(1'b1, {1'b0, ((i / 2) % 2) == 0}, 2'b00);
        repeat (12) drive(1'b1, 2'b01, 2'b00);
        settle();
        chk("bounce_press", n_press[0], 1);
        repeat (10) drive(1'b1, 2'b00, 2'b00);

        // Hold-to-repeat.
        clear_counts();
        repeat (46) drive(1'b1, 2'b01, 2'b01);
        settle();
        chk("repeat_count", n_rpt[0], m_rpt[0]);
        chk("repeat_press", n_press[0], 1);
        repeat (10) drive(1'b1, 2'b00, 2'b01);

        // repeat_en gated low for press+5..press+20.
        clear_counts();
        for (int i = 0; i < 46; i++) drive(1'b1, 2'b01, {1'b0, !(i >= 11 && i <= 26)});
        settle();
        chk("gating_count", n_rpt[0], m_rpt[0]);
        repeat (10) drive(1'b1, 2'b00, 2'b01);

        // Release lands on the cycle a repeat would fire.
        clear_counts();
        for (int i = 0; i < 30; i++) drive(1'b1, {1'b0, i < 13}, 2'b01);
        settle();
        chk("race_repeats", n_rpt[0], 1);
        chk("race_release", n_rel[0], 1);

        // ch0 repeating while ch1 is pressed and released.
        clear_counts();
        for (int i = 0; i < 60; i++) drive(1'b1, {(i >= 15 && i < 35), 1'b1}, 2'b01);
        settle();
        chk("indep_ch1_press", n_press[1], 1);
        chk("indep_ch1_release", n_rel[1], 1);
        chk("indep_ch0_repeat", n_rpt[0], m_rpt[0]);
        repeat (10) drive(1'b1, 2'b00, 2'b00);

        // Random bouncing, random gating, with a reset in the middle.
        clear_counts();
        lvl = '0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) lvl[c] = ~lvl[c];
                en[c] = ($urandom_range(0, 7) != 0);
            end
            drive(!(i >= 200 && i < 203), lvl, en);
        end
        settle();
        for (int c = 0; c < N; c++) begin
            chk("rand_press", n_press[c], m_press[c]);
            chk("rand_release", n_rel[c], m_rel[c]);
            chk("rand_repeat", n_rpt[c], m_rpt[c]);
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
